// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NREQ requesters, the FIFO write port and the arbiter.
// slave is the arbiter's view; master is the requester/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       last;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_ena;
  logic                  fifo_wra;
  logic [WIDTH-1:0]      fifo_dina;
  logic                  full;
  logic                  err_timeout;

  modport slave (
    input  req, last, din, full,
    output ack, gnt, fifo_ena, fifo_wra, fifo_dina, err_timeout
  );

  modport master (
    output req, last, din, full,
    input  ack, gnt, fifo_ena, fifo_wra, fifo_dina, err_timeout
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of an async FIFO; one packet or BURST words per grant.
// Define FIFO_ARB_WATCHDOG_EN to bound the packet lock with a TIMEOUT idle-cycle watchdog.
module fifo_wr_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int BURST   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [NREQ-1:0]  ge_mask, req_hi, cand, pick;
  logic [PW-1:0]    g_idx, g_next;
  logic [WIDTH-1:0] dina;
  logic             owner_req, owner_last, accept, release_grant, wd_fire;

  if (NREQ < 2 || NREQ > 8 || BURST < 1 || BURST > 255 ||
      TIMEOUT < 2 || TIMEOUT > 255 || WIDTH < 1) begin : g_param_check
    $error("fifo_wr_arbiter: parameter out of range");
  end

  // First requester at or above rr_ptr wins; otherwise wrap to the lowest one.
  always_comb begin : rr_pick
    ge_mask = ~((NREQ'(1) << rr_ptr_q) - NREQ'(1));
    req_hi  = bus.req & ge_mask;
    cand    = (req_hi != '0) ? req_hi : bus.req;
    pick    = cand & (~cand + NREQ'(1));
  end

  always_comb begin : owner_decode
    g_idx = '0;
    dina  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) g_idx = PW'(i);
      dina |= bus.din[i*WIDTH +: WIDTH] & {WIDTH{gnt_q[i]}};
    end
    g_next = (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + PW'(1);
  end

  assign owner_req  = |(gnt_q & bus.req);
  assign owner_last = |(gnt_q & bus.last);
  // Reset cycle never writes, so an interrupted grant is dropped cleanly.
  assign accept     = (state_q == BUSY) && owner_req && !bus.full && !rst;
  assign release_grant = (accept && (owner_last || (cnt_q + CW'(1) == CW'(BURST)))) || wd_fire;

`ifdef FIFO_ARB_WATCHDOG_EN
  localparam int IW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] idle_q, idle_d;
  logic          err_timeout_q, err_timeout_d;

  assign wd_fire = (state_q == BUSY) && !owner_req && !bus.full &&
                   (idle_q + IW'(1) == IW'(TIMEOUT));

  // Full-stalled cycles are not idle: the owner may simply be waiting for space.
  always_comb begin : wd_next
    idle_d        = idle_q;
    err_timeout_d = wd_fire;
    if (state_q == IDLE || owner_req || wd_fire) idle_d = '0;
    else if (!bus.full)                         idle_d = idle_q + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      idle_q        <= idle_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign bus.err_timeout = err_timeout_q;
`else
  assign wd_fire         = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  always_comb begin : next_state
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req != '0) begin
          state_d = BUSY;
          gnt_d   = pick;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (release_grant) begin
          state_d  = IDLE;
          gnt_d    = '0;
          cnt_d    = '0;
          rr_ptr_d = g_next;
        end else if (accept) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = gnt_q & bus.req & {NREQ{accept}};
  assign bus.fifo_ena  = accept;
  assign bus.fifo_wra  = accept;
  assign bus.fifo_dina = dina;
endmodule
